// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: ownership encoding and the
// request bundle presented by each requester.
package dmem_arb_pkg;

  localparam int DMEM_ADDR_W = 9;
  localparam int DMEM_DATA_W = 32;

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_e;

  typedef struct packed {
    logic                   req;
    logic                   we;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_arb_grant.sv
// Combinational fairness rule: picks at most one requester from the
// current requests, the last owner and its consecutive-grant count.
module dmem_arb_grant
  import dmem_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic                               cpu_req,
  input  logic                               dma_req,
  input  owner_e                             owner,
  input  logic [$clog2(MAX_BURST+1)-1:0]     burst_cnt,
  output logic                               cpu_gnt,
  output logic                               dma_gnt
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  logic owner_may_continue;

  always_comb begin
    owner_may_continue = (burst_cnt < MAX_CNT);
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (cpu_req && !dma_req) begin
      cpu_gnt = 1'b1;
    end else if (!cpu_req && dma_req) begin
      dma_gnt = 1'b1;
    end else if (cpu_req && dma_req) begin
      // Under contention the current owner keeps the port until its run is used up.
      unique case (owner)
        OWN_CPU: begin
          cpu_gnt = owner_may_continue;
          dma_gnt = !owner_may_continue;
        end
        OWN_DMA: begin
          dma_gnt = owner_may_continue;
          cpu_gnt = !owner_may_continue;
        end
        default: cpu_gnt = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core load/store path and
// a secondary requester, bounding consecutive grants and steering read data.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W    = DMEM_DATA_W,
  parameter int ADDR_W    = DMEM_ADDR_W,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  owner_e           owner_q, owner_d;
  owner_e           rsel_q, rsel_d;
  owner_e           gnt_owner;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             rpend_q, rpend_d;
  logic             cpu_req_en, dma_req_en;
  logic             cpu_granted, dma_granted, granted, gnt_we;

  // Requests are masked while reset is held so nothing reaches memory.
  assign cpu_req_en = cpu_req & reset;
  assign dma_req_en = dma_req & reset;

  dmem_arb_grant #(
    .MAX_BURST (MAX_BURST)
  ) u_grant (
    .cpu_req   (cpu_req_en),
    .dma_req   (dma_req_en),
    .owner     (owner_q),
    .burst_cnt (burst_cnt_q),
    .cpu_gnt   (cpu_granted),
    .dma_gnt   (dma_granted)
  );

  always_comb begin
    granted   = cpu_granted | dma_granted;
    gnt_owner = dma_granted ? OWN_DMA : OWN_CPU;
    gnt_we    = dma_granted ? dma_we : cpu_we;
    mem_addr  = dma_granted ? dma_addr : cpu_addr;
    mem_wdata = dma_granted ? dma_wdata : cpu_wdata;
    mem_wr    = granted & gnt_we;
    mem_rd    = granted & ~gnt_we;

    owner_d     = OWN_NONE;
    burst_cnt_d = '0;
    rsel_d      = rsel_q;
    rpend_d     = 1'b0;
    if (granted) begin
      owner_d = gnt_owner;
      if (gnt_owner == owner_q) begin
        burst_cnt_d = (burst_cnt_q == MAX_CNT) ? burst_cnt_q : burst_cnt_q + CNT_W'(1);
      end else begin
        burst_cnt_d = CNT_W'(1);
      end
      rpend_d = ~gnt_we;
      rsel_d  = gnt_owner;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      owner_q     <= OWN_NONE;
      burst_cnt_q <= '0;
      rsel_q      <= OWN_CPU;
      rpend_q     <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      rsel_q      <= rsel_d;
      rpend_q     <= rpend_d;
    end
  end

  assign cpu_stall  = cpu_req & ~cpu_granted;
  assign dma_gnt    = dma_req & dma_granted;
  assign cpu_rvalid = reset & rpend_q & (rsel_q == OWN_CPU);
  assign dma_rvalid = reset & rpend_q & (rsel_q == OWN_DMA);
  assign cpu_rdata  = mem_rdata;
  assign dma_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized checks of dmem_arbiter against a behavioural
// model of the grant rule, a reference memory image and a read-return tracker.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 9;
  localparam int MAX_BURST = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  dmem_req_t         cpu_s, dma_s;
  logic              cpu_req, cpu_we, dma_req, dma_we;
  logic [ADDR_W-1:0] cpu_addr, dma_addr, mem_addr;
  logic [DATA_W-1:0] cpu_wdata, dma_wdata, mem_wdata, mem_rdata;
  logic              cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, mem_wr, mem_rd;
  logic [DATA_W-1:0] cpu_rdata, dma_rdata;

  assign {cpu_req, cpu_we, cpu_addr, cpu_wdata} = cpu_s;
  assign {dma_req, dma_we, dma_addr, dma_wdata} = dma_s;

  dmem_arbiter #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .mem_wr     (mem_wr),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Synchronous single-port memory with a bench-side preload port.
  logic [DATA_W-1:0] mem_arr [2**ADDR_W];
  logic [DATA_W-1:0] rdata_r;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  assign mem_rdata = rdata_r;

  always @(posedge clk) begin
    if (ld_en) mem_arr[ld_addr] <= ld_data;
    else if (mem_wr) mem_arr[mem_addr] <= mem_wdata;
    if (mem_rd) rdata_r <= mem_arr[mem_addr];
  end

  // Reference model: side numbers 0 = none, 1 = CPU, 2 = DMA; run is unbounded.
  logic [DATA_W-1:0] ref_mem [2**ADDR_W];
  int                m_last, m_run, m_rsel;
  bit                m_rpend;
  logic [DATA_W-1:0] m_rdata;

  int n_chk = 0;
  int n_fail = 0;

  int                cap_g;
  logic              cap_stall, cap_dgnt, cap_mwr, cap_crv, cap_drv;
  logic [ADDR_W-1:0] cap_maddr;
  logic [DATA_W-1:0] cap_crd, cap_drd, exp4, exp8;
  int                exp_seq [10] = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called just after a falling edge with inputs already applied; returns at the next falling edge.
  task automatic cycle();
    int                g;
    logic              we, exp_crv, exp_drv;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] wd;
    #1;
    if (!rst_n || (!cpu_s.req && !dma_s.req)) g = 0;
    else if (!dma_s.req) g = 1;
    else if (!cpu_s.req) g = 2;
    else if (m_last == 0) g = 1;
    else if (m_run < MAX_BURST) g = m_last;
    else g = 3 - m_last;
    we = (g == 2) ? dma_s.we : cpu_s.we;
    a  = (g == 2) ? dma_s.addr : cpu_s.addr;
    wd = (g == 2) ? dma_s.wdata : cpu_s.wdata;

    cap_g     = dma_gnt ? 2 : ((cpu_req && !cpu_stall) ? 1 : 0);
    cap_stall = cpu_stall;
    cap_dgnt  = dma_gnt;
    cap_mwr   = mem_wr;
    cap_maddr = mem_addr;
    cap_crv   = cpu_rvalid;
    cap_crd   = cpu_rdata;
    cap_drv   = dma_rvalid;
    cap_drd   = dma_rdata;

    chk("grant", cap_g, g);
    chk("cpu_stall", cpu_stall, cpu_s.req && (g != 1));
    chk("dma_gnt", dma_gnt, g == 2);
    chk("mem_wr", mem_wr, (g != 0) && we);
    chk("mem_rd", mem_rd, (g != 0) && !we);
    if (g != 0) begin
      chk("mem_addr", mem_addr, a);
      if (we) chk("mem_wdata", mem_wdata, wd);
    end
    exp_crv = rst_n && m_rpend && (m_rsel == 1);
    exp_drv = rst_n && m_rpend && (m_rsel == 2);
    chk("cpu_rvalid", cpu_rvalid, exp_crv);
    chk("dma_rvalid", dma_rvalid, exp_drv);
    if (exp_crv) chk("cpu_rdata", cpu_rdata, m_rdata);
    if (exp_drv) chk("dma_rdata", dma_rdata, m_rdata);

    @(posedge clk);
    if (g == 0) begin
      m_last  = 0;
      m_run   = 0;
      m_rpend = 0;
    end else begin
      m_run  = (g == m_last) ? m_run + 1 : 1;
      m_last = g;
      if (we) begin
        ref_mem[a] = wd;
        m_rpend    = 0;
      end else begin
        m_rdata = ref_mem[a];
        m_rpend = 1;
        m_rsel  = g;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_s = '0;
    dma_s = '0;
    ld_en = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    m_last = 0; m_run = 0; m_rsel = 1; m_rpend = 0; m_rdata = '0;

    @(negedge clk);
    for (int i = 0; i < 2**ADDR_W; i++) begin
      ld_en   = 1'b1;
      ld_addr = i[ADDR_W-1:0];
      ld_data = (i == 16) ? 32'hDEADBEEF : $urandom;
      ref_mem[i] = ld_data;
      @(negedge clk);
    end
    ld_en = 1'b0;

    // Held in reset with both requesting: no grants, stall follows cpu_req.
    cpu_s = '{req: 1'b1, we: 1'b0, addr: 9'h020, wdata: '0};
    dma_s = '{req: 1'b1, we: 1'b1, addr: 9'h021, wdata: 32'h1234};
    cycle();
    cycle();
    chk("rst_stall", cap_stall, 1'b1);
    chk("rst_owner", dut.owner_q, OWN_NONE);
    rst_n = 1'b1;
    cpu_s = '0;
    dma_s = '0;
    cycle();

    // CPU read of preloaded word.
    cpu_s = '{req: 1'b1, we: 1'b0, addr: 9'h010, wdata: '0};
    cycle();
    chk("t1_stall", cap_stall, 1'b0);
    cpu_s = '0;
    cycle();
    chk("t1_rvalid", cap_crv, 1'b1);
    chk("t1_rdata", cap_crd, 32'hDEADBEEF);
    chk("t1_dma_rvalid", cap_drv, 1'b0);

    // Contention from idle.
    cpu_s = '{req: 1'b1, we: 1'b0, addr: 9'h020, wdata: '0};
    dma_s = '{req: 1'b1, we: 1'b0, addr: 9'h030, wdata: '0};
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("t2_grant", cap_g, exp_seq[i]);
      chk("t2_stall", cap_stall, (i >= 4) && (i < 8));
    end
    cpu_s = '0;
    dma_s = '0;
    cycle();

    // DMA write then CPU read-back.
    dma_s = '{req: 1'b1, we: 1'b1, addr: 9'h1FF, wdata: 32'h00000055};
    cycle();
    chk("t3_dgnt", cap_dgnt, 1'b1);
    chk("t3_mem_wr", cap_mwr, 1'b1);
    chk("t3_mem_addr", cap_maddr, 9'h1FF);
    dma_s = '0;
    cpu_s = '{req: 1'b1, we: 1'b0, addr: 9'h1FF, wdata: '0};
    cycle();
    cpu_s = '0;
    cycle();
    chk("t3_rvalid", cap_crv, 1'b1);
    chk("t3_rdata", cap_crd, 32'h00000055);

    // Interleaved reads.
    exp4 = ref_mem[4];
    exp8 = ref_mem[8];
    cpu_s = '{req: 1'b1, we: 1'b0, addr: 9'h004, wdata: '0};
    cycle();
    cpu_s = '0;
    dma_s = '{req: 1'b1, we: 1'b0, addr: 9'h008, wdata: '0};
    cycle();
    chk("t4_c_rv", cap_crv, 1'b1);
    chk("t4_c_d_rv", cap_drv, 1'b0);
    chk("t4_c_data", cap_crd, exp4);
    dma_s = '0;
    cycle();
    chk("t4_d_c_rv", cap_crv, 1'b0);
    chk("t4_d_rv", cap_drv, 1'b1);
    chk("t4_d_data", cap_drd, exp8);
    cycle();
    chk("t4_end_c_rv", cap_crv, 1'b0);
    chk("t4_end_d_rv", cap_drv, 1'b0);

    // Reset right after a granted read drops the response.
    cpu_s = '{req: 1'b1, we: 1'b0, addr: 9'h010, wdata: '0};
    cycle();
    cpu_s = '0;
    rst_n = 1'b0;
    cycle();
    chk("t5_rvalid", cap_crv, 1'b0);
    chk("t5_owner", dut.owner_q, OWN_NONE);
    chk("t5_burst", dut.burst_cnt_q, 0);
    rst_n = 1'b1;
    cpu_s = '{req: 1'b1, we: 1'b0, addr: 9'h0AA, wdata: '0};
    dma_s = '{req: 1'b1, we: 1'b0, addr: 9'h0BB, wdata: '0};
    cycle();
    chk("t5_first_gnt", cap_g, 1);
    cpu_s = '0;
    cycle();
    dma_s = '0;
    cycle();

    // Saturated CPU run, then DMA arrives with the CPU still requesting.
    cpu_s = '{req: 1'b1, we: 1'b0, addr: 9'h040, wdata: '0};
    for (int i = 0; i < 6; i++) cycle();
    dma_s = '{req: 1'b1, we: 1'b1, addr: 9'h041, wdata: $urandom};
    cycle();
    chk("t6a_grant", cap_g, 2);
    chk("t6a_stall", cap_stall, 1'b1);
    dma_s = '0;
    cycle();
    cpu_s = '0;
    cycle();

    // Same, but the CPU drops its request as the DMA arrives.
    cpu_s = '{req: 1'b1, we: 1'b1, addr: 9'h042, wdata: $urandom};
    for (int i = 0; i < 6; i++) cycle();
    cpu_s = '0;
    dma_s = '{req: 1'b1, we: 1'b0, addr: 9'h042, wdata: '0};
    cycle();
    chk("t6b_grant", cap_g, 2);
    chk("t6b_stall", cap_stall, 1'b0);
    dma_s = '0;
    cycle();

    // Randomized traffic; a waiting requester holds its fields.
    for (int n = 0; n < 3000; n++) begin
      if (!(cpu_s.req && cap_stall)) begin
        cpu_s.req   = ($urandom_range(0, 9) < 7);
        cpu_s.we    = 1'($urandom_range(0, 1));
        cpu_s.addr  = 9'($urandom_range(0, 31));
        cpu_s.wdata = $urandom;
      end
      if (!(dma_s.req && !cap_dgnt)) begin
        dma_s.req   = ($urandom_range(0, 9) < 6);
        dma_s.we    = 1'($urandom_range(0, 1));
        dma_s.addr  = 9'($urandom_range(0, 31));
        dma_s.wdata = $urandom;
      end
      rst_n = ($urandom_range(0, 199) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
